waitx_client: RTL and testbench

Synchronous initiator for the WAITX two-way wait element. It drives the WAITX `ctrl` line with a 4-phase return-to-zero handshake and synchronizes the asynchronous `g1`/`g2` grants into the clock domain. It reports which input won, or a timeout, to a clocked consumer over a valid/ready interface. It sits between the A2A WAITX macro and the digital control logic that samples analog event detectors.

---
 rtl/waitx_pkg.sv | 25 ++
 rtl/sync_ndff.sv | 28 ++
 rtl/waitx_client.sv | 138 +++++++++++++
 tb/tb_waitx_client.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/waitx_pkg.sv
// waitx_pkg: shared types and constants for the WAITX client.
//   state_t    - client FSM states
//   RSP_*      - response codes reported on rsp_code
//   grant_code - maps a pair of synchronized grants onto a response code
package waitx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] RSP_TIMEOUT = 2'b00;
  localparam logic [1:0] RSP_G1      = 2'b01;
  localparam logic [1:0] RSP_G2      = 2'b10;
  localparam logic [1:0] RSP_BOTH    = 2'b11;

  // The code bits line up with the grants: bit0 = g1, bit1 = g2,
  // so both high maps to RSP_BOTH.
  function automatic logic [1:0] grant_code(input logic g1, input logic g2);
    return {g2, g1};
  endfunction

endpackage

// File: rtl/sync_ndff.sv
// sync_ndff: N-flop synchronizer for one asynchronous level signal.
//   clk - destination clock
//   rst - synchronous active-high reset, clears every stage
//   d   - asynchronous input
//   q   - synchronized output, STAGES rising edges after d settles
module sync_ndff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain; stage 0 is the only flop that samples the async input.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/waitx_client.sv
// waitx_client: clocked initiator for the WAITX two-way wait element.
// Arms ctrl with a 4-phase return-to-zero handshake, synchronizes the
// g1/g2 grants and reports the winner (or a timeout) on a valid/ready port.
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - consumer asks for one wait cycle
//   ctrl                - registered WAITX arm line
//   g1, g2              - asynchronous grants from the WAITX macro
//   rsp_valid/rsp_ready - result handshake, rsp_code holds the result
//   cnt_g1, cnt_g2      - saturating win counters
//   err                 - sticky flag, both grants seen together
module waitx_client
  import waitx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             ctrl,
  input  logic             g1,
  input  logic             g2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_code,
  output logic [CNT_W-1:0] cnt_g1,
  output logic [CNT_W-1:0] cnt_g2,
  output logic             err
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic g1_s, g2_s;
  state_t state, state_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
  logic [1:0] code, code_next;
  logic err_next, inc_g1, inc_g2;

  sync_ndff #(.STAGES(SYNC_STAGES)) u_sync_g1 (.clk(clk), .rst(rst), .d(g1), .q(g1_s));
  sync_ndff #(.STAGES(SYNC_STAGES)) u_sync_g2 (.clk(clk), .rst(rst), .d(g2), .q(g2_s));

  // Next-state, timeout counter, response code and error decisions.
  always_comb begin
    state_next = state;
    tmo_next   = tmo_cnt;
    code_next  = code;
    err_next   = err;
    inc_g1     = 1'b0;
    inc_g2     = 1'b0;
    case (state)
      ST_IDLE: begin
        // Grants are deliberately ignored here.
        if (req_valid && req_ready) begin
          state_next = ST_ARM;
          tmo_next   = '0;
          code_next  = RSP_TIMEOUT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ARM: begin
        // A grant on the last timeout cycle still counts as a win.
        if (g1_s || g2_s) begin
          code_next  = grant_code(g1_s, g2_s);
          err_next   = err | (g1_s & g2_s);
          state_next = ST_RELEASE;
        end else if (tmo_cnt == TMO_LAST) begin
          code_next  = RSP_TIMEOUT;
          state_next = ST_RELEASE;
        end else begin
          tmo_next = tmo_cnt + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        if (g1_s && g2_s) begin
          code_next = RSP_BOTH;
          err_next  = 1'b1;
        end else if (g1_s || g2_s) begin
          // Late win: only a timed-out result may be replaced.
          if (code == RSP_TIMEOUT) begin
            code_next = grant_code(g1_s, g2_s);
          end else begin
            code_next = code;
          end
        end else begin
          state_next = ST_RESP;
          inc_g1     = (code == RSP_G1);
          inc_g2     = (code == RSP_G2);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RESP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; handshake outputs follow state_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      code      <= RSP_TIMEOUT;
      err       <= 1'b0;
      cnt_g1    <= '0;
      cnt_g2    <= '0;
      ctrl      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_next;
      tmo_cnt   <= tmo_next;
      code      <= code_next;
      err       <= err_next;
      ctrl      <= (state_next == ST_ARM);
      req_ready <= (state_next == ST_IDLE);
      rsp_valid <= (state_next == ST_RESP);
      if (inc_g1 && (cnt_g1 != {CNT_W{1'b1}})) begin
        cnt_g1 <= cnt_g1 + CNT_W'(1);
      end
      if (inc_g2 && (cnt_g2 != {CNT_W{1'b1}})) begin
        cnt_g2 <= cnt_g2 + CNT_W'(1);
      end
    end
  end

  assign rsp_code = code;

endmodule

// File: tb/tb_waitx_client.sv
// tb_waitx_client: directed bench for waitx_client with a response scoreboard.
module tb_waitx_client;
  import waitx_pkg::*;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, ctrl, g1, g2;
  logic       rsp_valid, rsp_ready, err;
  logic [1:0] rsp_code, cnt_g1, cnt_g2;

  typedef struct {
    logic [1:0] code;
    logic [1:0] c1;
    logic [1:0] c2;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  waitx_client #(.SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .ctrl(ctrl), .g1(g1), .g2(g2), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_code(rsp_code), .cnt_g1(cnt_g1),
    .cnt_g2(cnt_g2), .err(err)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req();
    int k = 0;
    while (!req_ready && k < 50) begin step(1); k++; end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    check("ctrl_rise", ctrl, 1);
  endtask

  task automatic wait_ctrl_low();
    int k = 0;
    while (ctrl && k < 40) begin step(1); k++; end
    check("ctrl_fall_wait", ctrl, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!req_ready && k < 60) begin step(1); k++; end
    check("idle_wait", req_ready, 1);
  endtask

  task automatic push(input logic [1:0] c, input logic [1:0] c1,
                      input logic [1:0] c2, input logic e);
    exp_t x;
    x.code = c; x.c1 = c1; x.c2 = c2; x.err = e;
    sb.push_back(x);
  endtask

  task automatic grant_win(input logic w1, input logic w2, input int dly);
    do_req();
    step(dly);
    g1 = w1;
    g2 = w2;
    wait_ctrl_low();
    step(2);
    g1 = 1'b0;
    g2 = 1'b0;
    wait_idle();
  endtask

  // Monitor: every completed response transfer is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_code", rsp_code, e.code);
        check("cnt_g1", cnt_g1, e.c1);
        check("cnt_g2", cnt_g2, e.c2);
        check("err", err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int k;
    rst = 1'b1; g1 = 1'b1; g2 = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;

    // Reset with g1 held high.
    step(3);
    check("rst_ctrl", ctrl, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cnt_g1", cnt_g1, 0);
    check("rst_err", err, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_code", rsp_code, 0);
    rst = 1'b0; g1 = 1'b0;
    step(1);
    check("post_rst_req_ready", req_ready, 1);

    // g1 win with exact edge timing (accept edge 0).
    push(RSP_G1, 2'd1, 2'd0, 1'b0);
    do_req();
    step(3);
    g1 = 1'b1;
    step(2);
    check("ctrl_hold_g1", ctrl, 1);
    step(1);
    check("ctrl_fall_g1", ctrl, 0);
    step(2);
    g1 = 1'b0;
    step(2);
    check("rsp_valid_early", rsp_valid, 0);
    step(1);
    check("rsp_valid_rise", rsp_valid, 1);
    wait_idle();

    // g2 win held under backpressure.
    push(RSP_G2, 2'd1, 2'd1, 1'b0);
    rsp_ready = 1'b0;
    do_req();
    step(1);
    g2 = 1'b1;
    wait_ctrl_low();
    step(2);
    g2 = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin step(1); k++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_code", rsp_code, RSP_G2);
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    check("bp_single_transfer", rsp_valid, 0);
    wait_idle();

    // Timeout: ctrl high for exactly 16 cycles.
    push(RSP_TIMEOUT, 2'd1, 2'd1, 1'b0);
    do_req();
    hi = 0;
    while (ctrl && hi < 40) begin hi++; step(1); end
    check("timeout_ctrl_cycles", hi, 16);
    wait_idle();

    // Late g2: first synchronized during the first RELEASE cycle.
    push(RSP_G2, 2'd1, 2'd2, 1'b0);
    do_req();
    step(14);
    g2 = 1'b1;
    check("late_ctrl_still_high", ctrl, 1);
    step(2);
    check("late_ctrl_low", ctrl, 0);
    step(1);
    g2 = 1'b0;
    wait_idle();

    // Both grants together, then err stays set over the next request.
    push(RSP_BOTH, 2'd1, 2'd2, 1'b1);
    grant_win(1'b1, 1'b1, 1);
    push(RSP_G1, 2'd2, 2'd2, 1'b1);
    grant_win(1'b1, 1'b0, 1);

    // Saturation of the 2-bit g1 counter.
    for (int i = 0; i < 4; i++) begin
      push(RSP_G1, 2'd3, 2'd2, 1'b1);
      grant_win(1'b1, 1'b0, 2);
    end
    check("sat_cnt_g1", cnt_g1, 3);

    // Reset in the middle of ARM.
    do_req();
    step(3);
    check("mid_arm_ctrl", ctrl, 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_ctrl", ctrl, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_cnt_g1", cnt_g1, 0);
    check("mid_rst_cnt_g2", cnt_g2, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    step(1);
    check("mid_rst_ready_after", req_ready, 1);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
